// File: rtl/skinny_sbox8_dom1_layer_driver.sv
// Feeds a two-share state byte by byte through one 4-cycle DOM1 SKINNY sbox8
// and reassembles the substituted two-share state, MSB byte first.
module skinny_sbox8_dom1_layer_driver #(
    parameter int NBYTES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] state_in0,
    input  logic [8*NBYTES-1:0] state_in1,
    input  logic [7:0]          rnd,
    output logic [7:0]          si0,
    output logic [7:0]          si1,
    output logic [7:0]          r,
    output logic [3:0]          en,
    input  logic [7:0]          bo0,
    input  logic [7:0]          bo1,
    output logic [8*NBYTES-1:0] state_out0,
    output logic [8*NBYTES-1:0] state_out1,
    output logic                busy,
    output logic                done
);
    localparam int W  = 8 * NBYTES;
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [W-1:0]  in0_q, in0_d, in1_q, in1_d;
    logic [W-1:0]  out0_q, out0_d, out1_q, out1_d;
    logic [7:0]    si0_q, si0_d, si1_q, si1_d, r_q, r_d;
    logic [3:0]    en_q, en_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          capture_s;

    // Next-state, operand sequencing and result capture
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        byte_d    = byte_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        si0_d     = si0_q;
        si1_d     = si1_q;
        r_d       = r_q;
        done_d    = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    si0_d   = state_in0[W-1 -: 8];
                    si1_d   = state_in1[W-1 -: 8];
                    in0_d   = state_in0 << 8;
                    in1_d   = state_in1 << 8;
                    r_d     = rnd;
                    phase_d = 2'd0;
                    byte_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                phase_d   = phase_q + 2'd1;
                // Previous byte's result is ready once the next byte enters phase 0
                capture_s = (phase_q == 2'd0) && (byte_q != '0);
                if (phase_q == 2'd3) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = FLUSH;
                    end else begin
                        si0_d  = in0_q[W-1 -: 8];
                        si1_d  = in1_q[W-1 -: 8];
                        in0_d  = in0_q << 8;
                        in1_d  = in1_q << 8;
                        r_d    = rnd;
                        byte_d = byte_q + BW'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                capture_s = 1'b1;
                phase_d   = 2'd0;
                byte_d    = '0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture_s) begin
            out0_d = (out0_q << 8) | W'(bo0);
            out1_d = (out1_q << 8) | W'(bo1);
        end else begin
            out0_d = out0_q;
            out1_d = out1_q;
        end

        if (state_d == RUN) begin
            en_d = 4'b0001 << phase_d;
        end else begin
            en_d = 4'b0000;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            byte_q  <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            si0_q   <= 8'h00;
            si1_q   <= 8'h00;
            r_q     <= 8'h00;
            en_q    <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            byte_q  <= byte_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            si0_q   <= si0_d;
            si1_q   <= si1_d;
            r_q     <= r_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign si0        = si0_q;
    assign si1        = si1_q;
    assign r          = r_q;
    assign en         = en_q;
    assign state_out0 = out0_q;
    assign state_out1 = out1_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_skinny_sbox8_dom1_layer_driver.sv
// Directed bench for the sbox8 layer driver, with a behavioural 4-cycle
// masked sbox stand-in and a monitor for operand hold / enable sequencing.
module tb_skinny_sbox8_dom1_layer_driver;
    localparam int NB = 16;
    localparam int W  = 8 * NB;
    localparam logic [W-1:0] ZERO_IN  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [W-1:0] ZERO_EXP = 128'h654C6A424B63436B55755A7A53735B7B;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] state_in0 = '0;
    logic [W-1:0] state_in1 = '0;
    logic [7:0]   rnd = 8'h00;
    logic [7:0]   si0, si1, r;
    logic [3:0]   en;
    logic [7:0]   bo0 = 8'h00;
    logic [7:0]   bo1 = 8'h00;
    logic [W-1:0] state_out0, state_out1;
    logic         busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic         rnd_mode = 1'b0;
    logic         rst_at_edge = 1'b0;
    logic [7:0]   rnd_at_edge = 8'h00;
    logic [3:0]   prev_en = 4'b0000;
    logic [23:0]  held = 24'h0;
    logic [W-1:0] prev0, prev1, x_s, z_s, exp_s;
    int lat, dc;

    skinny_sbox8_dom1_layer_driver #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state_in0(state_in0), .state_in1(state_in1), .rnd(rnd),
        .si0(si0), .si1(si1), .r(r), .en(en), .bo0(bo0), .bo1(bo1),
        .state_out0(state_out0), .state_out1(state_out1),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] s8(input logic [7:0] xin);
        logic [7:0] x;
        x = xin;
        for (int k = 0; k < 3; k++) begin
            x = (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
            x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5)
              | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        x = (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sbox stand-in: result appears after the en[3] cycle, masked by r
    always @(posedge clk) begin
        if (en == 4'b1000) begin
            bo0 <= s8(si0 ^ si1) ^ r;
            bo1 <= r;
        end
    end

    always @(posedge clk) begin
        rst_at_edge <= rst_n;
        rnd_at_edge <= rnd;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rnd = rnd_mode ? 8'($urandom) : 8'h00;
        end
    end

    // Operand hold, fresh mask per byte and one-hot enable sequence
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst_at_edge) begin
            prev_en = 4'b0000;
        end else begin
            if (en == 4'b0001) begin
                held = {si0, si1, r};
                check("r_fresh", W'(r), W'(rnd_at_edge));
            end else if (en != 4'b0000) begin
                check("hold", W'({si0, si1, r}), W'(held));
            end
            if (prev_en == 4'b1000)
                check("en_wrap", W'(en == 4'b0001 || en == 4'b0000), W'(1'b1));
            else if (prev_en != 4'b0000)
                check("en_seq", W'(en), W'(prev_en << 1));
            else if (en != 4'b0000)
                check("en_start", W'(en), W'(4'b0001));
            prev_en = en;
        end
    end

    task automatic do_run(input logic [W-1:0] a0, input logic [W-1:0] a1,
                          input int ga, input int gb, input logic chk_hold,
                          output int latency);
        state_in0 = a0;
        state_in1 = a1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        latency = 1;
        while (!done && latency < 200) begin
            if (chk_hold && latency <= 5) begin
                check("held_out0", state_out0, prev0);
                check("held_out1", state_out1, prev1);
            end
            start = (latency == ga || latency == gb);
            @(posedge clk); #1;
            latency++;
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("idle_ctl", W'({en, busy, done}), W'(6'b0));
            check("idle_ops", W'({si0, si1, r}), W'(24'h0));
            check("idle_out", state_out0 | state_out1, '0);
            @(posedge clk); #1;
        end

        // Unmasked run against the published S8 values
        rnd_mode = 1'b0;
        do_run(ZERO_IN, '0, 0, 0, 1'b0, lat);
        check("lat_zero", W'(lat), W'(66));
        check("busy_at_done", W'(busy), W'(1'b0));
        check("s8_zero", state_out0 ^ state_out1, ZERO_EXP);
        prev0 = state_out0;
        prev1 = state_out1;
        dc = done_cnt;

        // Back-to-back masked run, with ignored starts at cycles 5 and 40
        rnd_mode = 1'b1;
        x_s = {$urandom, $urandom, $urandom, $urandom};
        do_run(x_s, x_s ^ {W{1'b1}}, 5, 40, 1'b1, lat);
        check("lat_b2b", W'(lat), W'(66));
        check("s8_ff", state_out0 ^ state_out1, {W{1'b1}});
        @(posedge clk); #1;
        check("done_pulse", W'({done, busy}), W'(2'b00));
        repeat (3) @(posedge clk);
        #1 check("done_count", W'(done_cnt - dc), W'(2));

        // Reset in the middle of a run
        state_in0 = x_s;
        state_in1 = ~x_s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_ctl", W'({en, busy, done}), W'(6'b0));
        check("rst_ops", W'({si0, si1, r}), W'(24'h0));
        check("rst_out", state_out0 | state_out1, '0);
        dc = done_cnt;
        repeat (70) @(posedge clk);
        #1 check("rst_no_done", W'(done_cnt), W'(dc));

        // Normal run after the abort, random data
        x_s = {$urandom, $urandom, $urandom, $urandom};
        z_s = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < NB; b++) exp_s[8*b +: 8] = s8(z_s[8*b +: 8]);
        do_run(x_s, x_s ^ z_s, 0, 0, 1'b0, lat);
        check("lat_after_rst", W'(lat), W'(66));
        check("s8_rand", state_out0 ^ state_out1, exp_s);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
